// File: rtl/xillybus_read_packer_if.sv
// Handshake bundle between a sample producer, the read packer and a Xillybus read port.
// The master drives samples and the host-side controls; the slave is the packer.
interface xillybus_read_packer_if #(
  parameter int BUS_W = 32,
  parameter int IN_W  = 8,
  parameter int DEPTH = 16
);
  localparam int FILL_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_data;
  logic              in_last;
  logic              user_r_rden;
  logic              user_r_open;
  logic [BUS_W-1:0]  user_r_data;
  logic              user_r_empty;
  logic              user_r_eof;
  logic [FILL_W-1:0] fill_level;

  modport master (
    output in_valid, in_data, in_last, user_r_rden, user_r_open,
    input  in_ready, user_r_data, user_r_empty, user_r_eof, fill_level
  );

  modport slave (
    input  in_valid, in_data, in_last, user_r_rden, user_r_open,
    output in_ready, user_r_data, user_r_empty, user_r_eof, fill_level
  );
endinterface

// File: rtl/xillybus_read_packer.sv
// Packs IN_W-bit samples little-endian into BUS_W-bit words, buffers them in a
// DEPTH-word FIFO and serves a standard (non-FWFT) Xillybus read port with EOF.
//
// state  | meaning
// S_PACK | accepting samples into the lane accumulator
// S_DONE | last-tagged word pushed; input blocked until the host closes
module xillybus_read_packer #(
  parameter int BUS_W = 32,
  parameter int IN_W  = 8,
  parameter int DEPTH = 16
) (
  input  logic                   bus_clk,
  input  logic                   bus_rst_n,
  xillybus_read_packer_if.slave  pk
);
  localparam int LANES  = BUS_W / IN_W;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;

  typedef enum logic {S_PACK, S_DONE} state_t;

  state_t              state_q;
  logic [LANE_W-1:0]   lane_q;
  logic [BUS_W-1:0]    acc_q;
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [FILL_W-1:0]   fill_q;
  logic [BUS_W-1:0]    rdata_q;
  logic                alive_q;
  logic [BUS_W-1:0]    mem [DEPTH];

  logic                in_ready;
  logic                accept;
  logic                last_lane;
  logic                push;
  logic                pop;
  logic [BUS_W-1:0]    word_d;

  // alive_q keeps in_ready low while reset is held, even if the host has the stream open
  assign in_ready  = alive_q && pk.user_r_open && (fill_q < FILL_W'(DEPTH)) && (state_q == S_PACK);
  assign accept    = pk.in_valid && in_ready;
  assign last_lane = (lane_q == LANE_W'(LANES - 1));
  assign push      = accept && (last_lane || pk.in_last);
  assign pop       = pk.user_r_open && pk.user_r_rden && (fill_q != '0);

  always_comb begin
    word_d = acc_q;
    word_d[int'(lane_q)*IN_W +: IN_W] = pk.in_data;
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      state_q  <= S_PACK;
      lane_q   <= '0;
      acc_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      rdata_q  <= '0;
      alive_q  <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      if (!pk.user_r_open) begin
        state_q  <= S_PACK;
        lane_q   <= '0;
        acc_q    <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        fill_q   <= '0;
      end else begin
        if (accept) begin
          if (push) begin
            acc_q    <= '0;
            lane_q   <= '0;
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pk.in_last) state_q <= S_DONE;
          end else begin
            acc_q  <= word_d;
            lane_q <= lane_q + LANE_W'(1);
          end
        end
        if (pop) begin
          rdata_q  <= mem[rd_ptr_q];
          rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   fill_q <= fill_q + FILL_W'(1);
          2'b01:   fill_q <= fill_q - FILL_W'(1);
          default: fill_q <= fill_q;
        endcase
      end
    end
  end

  always_ff @(posedge bus_clk) begin
    if (push) mem[wr_ptr_q] <= word_d;
  end

  assign pk.in_ready     = in_ready;
  assign pk.user_r_data  = rdata_q;
  assign pk.user_r_empty = (fill_q == '0);
  // only the last-tagged word can be pushed once S_DONE is entered, so empty means it was popped
  assign pk.user_r_eof   = (state_q == S_DONE) && (fill_q == '0);
  assign pk.fill_level   = fill_q;
endmodule

// File: tb/tb_xillybus_read_packer.sv
// Bench for xillybus_read_packer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_xillybus_read_packer;
  localparam int BUS_W = 32;
  localparam int IN_W  = 8;
  localparam int DEPTH = 16;
  localparam int LANES = BUS_W / IN_W;

  logic clk;
  logic rst_n;

  xillybus_read_packer_if #(.BUS_W(BUS_W), .IN_W(IN_W), .DEPTH(DEPTH)) pk ();

  xillybus_read_packer #(.BUS_W(BUS_W), .IN_W(IN_W), .DEPTH(DEPTH)) dut (
    .bus_clk   (clk),
    .bus_rst_n (rst_n),
    .pk        (pk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // reference model: a queue of whole words plus the partially built word
  logic [BUS_W-1:0] mq[$];
  logic [BUS_W-1:0] m_acc;
  int               m_lane;
  bit               m_done;
  bit               m_started;
  logic [BUS_W-1:0] m_data;

  function automatic bit exp_ready();
    return m_started && pk.user_r_open && (mq.size() < DEPTH) && !m_done;
  endfunction

  initial begin
    bit rdy;
    mq.delete(); m_acc = '0; m_lane = 0; m_done = 0; m_started = 0; m_data = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete(); m_acc = '0; m_lane = 0; m_done = 0; m_started = 0; m_data = '0;
      end else begin
        rdy = exp_ready();
        if (!pk.user_r_open) begin
          mq.delete(); m_acc = '0; m_lane = 0; m_done = 0;
        end else begin
          if (pk.user_r_rden && mq.size() != 0) m_data = mq.pop_front();
          if (pk.in_valid && rdy) begin
            m_acc[m_lane*IN_W +: IN_W] = pk.in_data;
            if (m_lane == LANES - 1 || pk.in_last) begin
              mq.push_back(m_acc);
              m_acc  = '0;
              m_lane = 0;
              if (pk.in_last) m_done = 1;
            end else begin
              m_lane++;
            end
          end
        end
        m_started = 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("in_ready", 64'(pk.in_ready),     64'(exp_ready()));
      chk("empty",    64'(pk.user_r_empty), 64'(mq.size() == 0));
      chk("eof",      64'(pk.user_r_eof),   64'(m_done && mq.size() == 0));
      chk("fill",     64'(pk.fill_level),   64'(mq.size()));
      chk("data",     64'(pk.user_r_data),  64'(m_data));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [IN_W-1:0] d, input logic l);
    int t = 0;
    logic r;
    pk.in_valid = 1'b1; pk.in_data = d; pk.in_last = l;
    do begin
      @(negedge clk); r = pk.in_ready;
      @(posedge clk); #1;
      t++;
    end while (!r && t < 200);
    if (!r) timeout_fail("send");
    pk.in_valid = 1'b0; pk.in_last = 1'b0;
  endtask

  task automatic pop1();
    pk.user_r_rden = 1'b1; step(); pk.user_r_rden = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    logic e;
    pk.user_r_rden = 1'b1;
    do begin
      @(negedge clk); e = pk.user_r_empty;
      @(posedge clk); #1;
      t++;
    end while (!e && t < 100);
    if (!e) timeout_fail("drain");
    pk.user_r_rden = 1'b0;
  endtask

  task automatic close1();
    pk.user_r_open = 1'b0; step(); pk.user_r_open = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    pk.in_valid = 1'b0; pk.in_data = '0; pk.in_last = 1'b0;
    pk.user_r_rden = 1'b0; pk.user_r_open = 1'b0;
    #2;
    chk("rst_data",  64'(pk.user_r_data), 64'h0);
    chk("rst_empty", 64'(pk.user_r_empty), 64'h1);
    chk("rst_ready", 64'(pk.in_ready), 64'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    pk.user_r_open = 1'b1;
    step(); step();

    // pack four samples into one word
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    @(negedge clk);
    chk("pack_fill",  64'(pk.fill_level), 64'd1);
    chk("pack_empty", 64'(pk.user_r_empty), 64'd0);
    step(); pop1();
    @(negedge clk);
    chk("pack_data",  64'(pk.user_r_data), 64'h44332211);
    chk("pack_empty2", 64'(pk.user_r_empty), 64'd1);
    chk("pack_eof",   64'(pk.user_r_eof), 64'd0);

    // partial flush then EOF
    step();
    send(8'hAA, 0); send(8'hBB, 1);
    @(negedge clk);
    chk("part_ready", 64'(pk.in_ready), 64'd0);
    chk("part_eof0",  64'(pk.user_r_eof), 64'd0);
    chk("part_fill",  64'(pk.fill_level), 64'd1);
    step(); pop1();
    @(negedge clk);
    chk("part_data",  64'(pk.user_r_data), 64'h0000BBAA);
    chk("part_eof1",  64'(pk.user_r_eof), 64'd1);
    chk("part_empty", 64'(pk.user_r_empty), 64'd1);
    step(); close1(); step();

    // backpressure: fill to DEPTH words without reading
    for (int i = 0; i < 64; i++) send(IN_W'($urandom), 0);
    @(negedge clk);
    chk("bp_fill",  64'(pk.fill_level), 64'(DEPTH));
    chk("bp_ready", 64'(pk.in_ready), 64'd0);
    step(); pop1();
    @(negedge clk);
    chk("bp_ready1", 64'(pk.in_ready), 64'd1);
    step();
    for (int i = 0; i < 4; i++) send(IN_W'($urandom), 0);
    @(negedge clk);
    chk("bp_refill", 64'(pk.fill_level), 64'(DEPTH));
    step(); drain();

    // concurrent push/pop holding fill at 8
    for (int i = 0; i < 32; i++) send(IN_W'($urandom), 0);
    for (int k = 0; k < 20; k++) begin
      pk.in_valid = 1'b1; pk.in_data = IN_W'($urandom); pk.in_last = 1'b0;
      pk.user_r_rden = (k % 4 == 3);
      @(negedge clk);
      chk("conc_fill", 64'(pk.fill_level), 64'd8);
      @(posedge clk); #1;
    end
    pk.in_valid = 1'b0; pk.user_r_rden = 1'b0;
    drain();

    // close mid-frame discards buffered words and stale lanes
    for (int i = 0; i < 22; i++) send(IN_W'($urandom), 0);
    @(negedge clk);
    chk("close_fill5", 64'(pk.fill_level), 64'd5);
    step();
    pk.user_r_open = 1'b0; step();
    @(negedge clk);
    chk("close_fill0", 64'(pk.fill_level), 64'd0);
    chk("close_empty", 64'(pk.user_r_empty), 64'd1);
    step(); pk.user_r_open = 1'b1;
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    step(); pop1();
    @(negedge clk);
    chk("close_word", 64'(pk.user_r_data), 64'h04030201);
    step();

    // async reset with eof high
    send(8'h5A, 1); step(); pop1();
    @(negedge clk);
    chk("rst_eof_pre", 64'(pk.user_r_eof), 64'd1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("arst_eof",   64'(pk.user_r_eof), 64'd0);
    chk("arst_empty", 64'(pk.user_r_empty), 64'd1);
    chk("arst_ready", 64'(pk.in_ready), 64'd0);
    chk("arst_data",  64'(pk.user_r_data), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step(); step();
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0); send(8'h05, 1);
    step(); drain();
    @(negedge clk);
    chk("post_rst_eof",  64'(pk.user_r_eof), 64'd1);
    chk("post_rst_data", 64'(pk.user_r_data), 64'h00000005);
    step(); close1();

    // randomized soak
    for (int c = 0; c < 600; c++) begin
      if (m_done && mq.size() == 0) pk.user_r_open = 1'b0;
      else pk.user_r_open = ($urandom_range(0, 60) != 0);
      pk.in_valid    = ($urandom_range(0, 3) != 0);
      pk.in_data     = IN_W'($urandom);
      pk.in_last     = ($urandom_range(0, 15) == 0);
      pk.user_r_rden = ($urandom_range(0, 2) == 0);
      step();
    end
    pk.in_valid = 1'b0; pk.user_r_rden = 1'b0; pk.user_r_open = 1'b1;
    step(); drain(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/xillybus_read_packer.md
Name: xillybus_read_packer

Overview:
Parametrised read-side adapter between a narrow result stream and a Xillybus FPGA-to-host read stream of BUS_W bits. It packs IN_W-bit samples little-endian into BUS_W-bit words and buffers them in a DEPTH-word FIFO. It presents the standard (non-FWFT) rden/empty/eof/open interface and generates EOF at frame end, with partial-word flush. It generalises the fixed 32-bit read path to any width ratio, adds frame termination, and flushes when the host closes the stream.

Parameters:
BUS_W, 32, Xillybus read word width; must be a multiple of IN_W.
IN_W, 8, input sample width; LANES = BUS_W/IN_W.
DEPTH, 16, FIFO depth in words; power of 2, at least 2.

Ports:
bus_clk  in  1  single clock for all logic.
bus_rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  sample valid.
in_ready  out  1  sample accepted when in_valid && in_ready.
in_data  in  IN_W  sample.
in_last  in  1  last sample of frame; qualified by the accept.
user_r_rden  in  1  Xillybus read enable.
user_r_open  in  1  host has the stream open.
user_r_data  out  BUS_W  read data; registered.
user_r_empty  out  1  FIFO empty.
user_r_eof  out  1  end of frame reached.
fill_level  out  clog2(DEPTH)+1  words currently in FIFO.

Behaviour:
- Reset (async assert, sync release): user_r_data=0, user_r_empty=1, user_r_eof=0, in_ready=0, fill_level=0, lane counter=0, frame_done=0, accumulator=0.
- in_ready = user_r_open && (fill_level<DEPTH) && !frame_done. Combinational from registered state only; never depends on in_valid.
- Packing:
  - Lane counter runs 0..LANES-1.
  - Accepted sample goes to bits [lane*IN_W +: IN_W].
  - A word is pushed on the accepting cycle when lane==LANES-1 or in_last=1.
  - Unfilled upper lanes are zero.
  - After a push, the lane counter returns to 0 and the accumulator clears.
  - The pushed word carries a last tag equal to in_last.
- Push of a last-tagged word sets frame_done. No further input is accepted until close.
- Read side, standard FIFO semantics:
  - On an edge with user_r_rden && !user_r_empty, the head word pops and is registered onto user_r_data. It is visible from the next cycle.
  - rden while empty is ignored; user_r_data holds.
- user_r_empty = (fill_level==0), registered/derived so it is valid the cycle after any push or pop.
- user_r_eof = frame_done && user_r_empty. It stays high until close, and asserts only once the last-tagged word has been popped.
- Simultaneous push and pop: fill_level is unchanged, and the data order is preserved.
- Full: in_ready=0. A pop at full raises in_ready on the following cycle.
- Close (user_r_open=0), synchronous each cycle it is low:
  - FIFO discarded (fill_level=0, empty=1).
  - Lane counter and accumulator cleared; frame_done=0, eof=0.
  - in_ready=0; rden ignored; user_r_data holds its last value.
- Reset mid-operation loses all buffered data. Outputs return to reset values immediately on assertion.
- Pointers are clog2(DEPTH) bits and wrap naturally. fill_level ranges 0..DEPTH.

Test Plan:
- Pack: IN_W=8, open=1; push 0x11,0x22,0x33,0x44 -> fill_level=1, empty deasserts; rden for 1 cycle -> user_r_data=0x44332211 the next cycle; empty=1, eof=0.
- Partial flush and EOF: push 0xAA, then 0xBB with in_last -> word 0x0000BBAA pushed; in_ready=0 while open; eof=0 until the pop; after the pop, user_r_eof=1 with empty=1.
- Backpressure: push 64 samples with rden=0 -> fill_level=16, in_ready=0; one rden -> in_ready=1 next cycle; further pushes fill the FIFO again with no loss or duplication (compare all 64 against a scoreboard).
- Concurrent push/pop at fill_level=8 for 20 cycles -> fill_level stays 8; output order matches input.
- Close mid-frame: 2 of 4 lanes filled and 5 words buffered; drop open for 1 cycle -> fill_level=0, empty=1; reopen and push 0x01..0x04 -> word 0x04030201 with no stale lanes.
- Reset mid-frame with eof=1: assert bus_rst_n=0 asynchronously -> eof=0, empty=1, in_ready=0 immediately; after release and open, a normal frame works.
